vga_fb_scanout: RTL
===================

Name: vga_fb_scanout

Overview:
- Downstream stage of the VGA area tracker. Consumes its coordinate, visible and sync outputs.
- Generates framebuffer read addresses for a synchronous-read pixel RAM, with power-of-two pixel/line replication.
- Re-aligns visible, h-sync and v-sync to the RAM read latency and emits blanked pixel data for the DAC/pins.
- Provides double-buffer swap, committed only at frame boundaries.

Parameters:
- P_CNT_WIDTH, 8, width of incoming h/v coordinates.
- P_ADDR_WIDTH, 16, framebuffer address width.
- P_PIX_WIDTH, 8, pixel data width (RGB332).
- P_FB_WIDTH, 160, framebuffer pixels per stored line.
- P_SCALE_SHIFT, 2, replication factor 2^n in both axes (0 = none).
- P_MEM_LATENCY, 1, RAM cycles from address to data (>=1).
- P_BUF0_BASE, 0, base address of buffer 0.
- P_BUF1_BASE, 19200, base address of buffer 1.

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- ia_h_coord  in  P_CNT_WIDTH  tracker horizontal coordinate
- ia_v_coord  in  P_CNT_WIDTH  tracker vertical coordinate (observability only; addressing does not use it)
- i_visible  in  1  tracker visible flag
- i_h_sync  in  1  tracker h-sync, active-high
- i_v_sync  in  1  tracker v-sync, active-high
- i_frame_sync  in  1  tracker last-line flag
- i_swap_req  in  1  one-cycle request to swap buffers
- oa_mem_addr  out  P_ADDR_WIDTH  RAM read address
- o_mem_rd_en  out  1  RAM read enable
- ia_mem_data  in  P_PIX_WIDTH  RAM read data
- oa_pixel  out  P_PIX_WIDTH  output pixel, zero when blanked
- o_h_sync  out  1  delayed h-sync
- o_v_sync  out  1  delayed v-sync
- o_swap_ack  out  1  one-cycle pulse when a swap commits
- o_active_buf  out  1  buffer currently scanned

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is asynchronous, active-low, on i_rst_n.
- Reset values:
  - All outputs 0.
  - Delay lines 0, swap_pending 0, line_rep 0.
  - row_base = P_BUF0_BASE, frame_sync_q = 0.
- Frame start: frame_start = frame_sync_q & ~i_frame_sync, i.e. the vertical coordinate has just wrapped to 0. frame_sync_q is i_frame_sync registered.
- Actions on frame_start:
  - line_rep <= 0.
  - row_base <= base of the buffer that is active after any swap this cycle.
- Line advance: on the falling edge of i_visible (visible_q & ~i_visible), when not frame_start:
  - line_rep increments modulo 2^P_SCALE_SHIFT.
  - When line_rep wraps to 0, row_base += P_FB_WIDTH.
- Address stage (stage 0, registered):
  - oa_mem_addr <= row_base + (ia_h_coord >> P_SCALE_SHIFT).
  - o_mem_rd_en <= i_visible.
  - Address arithmetic wraps modulo 2^P_ADDR_WIDTH.
  - The address is don't-care while o_mem_rd_en = 0.
- Data stage:
  - i_visible, i_h_sync and i_v_sync are delayed by 1 + P_MEM_LATENCY cycles.
  - oa_pixel is registered: oa_pixel <= vis_d ? ia_mem_data : 0.
  - Total latency from inputs to oa_pixel/o_h_sync/o_v_sync is 2 + P_MEM_LATENCY cycles, identical for all three.
- Swap handshake:
  - i_swap_req sets swap_pending.
  - On frame_start with (swap_pending | i_swap_req): o_active_buf toggles, o_swap_ack pulses one cycle, swap_pending clears.
  - i_swap_req coinciding with frame_start commits in that same frame.
  - Repeated requests before commit collapse to one swap.
  - i_swap_req during the frame_start cycle that also commits a pending swap does not re-arm.
- Mid-operation reset: all state returns to reset values immediately. After release, scanout resumes at the next tracker coordinates. Output stays blanked until vis_d propagates. Row addressing is correct only from the first frame_start after reset.

Decomposition:
- Shared package vga_pkg holds:
  - Timing constants for the standard 640x480 mode and the test mode.
  - The RGB332 pixel width constant.
  - Default buffer bases.
- One sub-module, vga_delay_line: parameters P_WIDTH and P_DEPTH; async active-low reset to 0. It is used for the vis/hsync/vsync bundle.

Test Plan:
- Tracker config H 8/1/2/1, V 4/1/1/1, P_SCALE_SHIFT=0, P_FB_WIDTH=8, latency 1, RAM returns its address:
  -> frame after reset shows pixels 0..7, 8..15, 16..23, 24..31.
  -> Latency 3 cycles; oa_pixel=0 whenever blanked.
- Same config, P_SCALE_SHIFT=1, P_FB_WIDTH=4:
  -> lines 0,1 read addresses 0,0,1,1,2,2,3,3.
  -> Lines 2,3 read 4,4,5,5,6,6,7,7.
- i_swap_req pulsed mid-frame 0:
  -> o_swap_ack is a single pulse in the frame_start cycle; o_active_buf=1.
  -> First visible address of the next frame = P_BUF1_BASE.
- i_swap_req asserted exactly in the frame_start cycle:
  -> Swap commits that cycle.
- Three requests in one frame:
  -> Exactly one ack and one toggle.
- P_MEM_LATENCY=3:
  -> o_h_sync rising edge is exactly 5 cycles after the i_h_sync rising edge; pixel/sync alignment is preserved.
- i_rst_n dropped mid-line for 2 cycles:
  -> All outputs 0 asynchronously; o_active_buf=0.
  -> Correct addressing from the next frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing, pixel format and framebuffer constants
package vga_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  // Reduced mode used to exercise the pipeline in a few hundred cycles
  localparam int TEST_H_VISIBLE = 8;
  localparam int TEST_H_FRONT   = 1;
  localparam int TEST_H_SYNC    = 2;
  localparam int TEST_H_BACK    = 1;
  localparam int TEST_V_VISIBLE = 4;
  localparam int TEST_V_FRONT   = 1;
  localparam int TEST_V_SYNC    = 1;
  localparam int TEST_V_BACK    = 1;

  localparam int RGB332_WIDTH = 8;

  localparam int FB_BUF0_BASE = 0;
  localparam int FB_BUF1_BASE = 19200;

  typedef struct packed {
    logic visible;
    logic h_sync;
    logic v_sync;
  } vga_ctl_t;

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth register delay line, async active-low reset to 0
module vga_delay_line #(
  parameter int P_WIDTH = 1,
  parameter int P_DEPTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [P_WIDTH-1:0] data,
  output logic [P_WIDTH-1:0] delayed
);

  logic [P_WIDTH-1:0] stage [P_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < P_DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= data;
      for (int i = 1; i < P_DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign delayed = stage[P_DEPTH-1];

endmodule

// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - framebuffer read addressing, latency-matched sync and blanked pixel out
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int P_CNT_WIDTH   = 8,
  parameter int P_ADDR_WIDTH  = 16,
  parameter int P_PIX_WIDTH   = RGB332_WIDTH,
  parameter int P_FB_WIDTH    = 160,
  parameter int P_SCALE_SHIFT = 2,
  parameter int P_MEM_LATENCY = 1,
  parameter int P_BUF0_BASE   = FB_BUF0_BASE,
  parameter int P_BUF1_BASE   = FB_BUF1_BASE
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [P_CNT_WIDTH-1:0]  ia_h_coord,
  input  logic [P_CNT_WIDTH-1:0]  ia_v_coord,
  input  logic                    i_visible,
  input  logic                    i_h_sync,
  input  logic                    i_v_sync,
  input  logic                    i_frame_sync,
  input  logic                    i_swap_req,
  output logic [P_ADDR_WIDTH-1:0] oa_mem_addr,
  output logic                    o_mem_rd_en,
  input  logic [P_PIX_WIDTH-1:0]  ia_mem_data,
  output logic [P_PIX_WIDTH-1:0]  oa_pixel,
  output logic                    o_h_sync,
  output logic                    o_v_sync,
  output logic                    o_swap_ack,
  output logic                    o_active_buf
);

  localparam int REP_W = (P_SCALE_SHIFT > 0) ? P_SCALE_SHIFT : 1;
  localparam logic [REP_W-1:0]        REP_LAST = REP_W'((1 << P_SCALE_SHIFT) - 1);
  localparam logic [P_ADDR_WIDTH-1:0] BASE0    = P_ADDR_WIDTH'(P_BUF0_BASE);
  localparam logic [P_ADDR_WIDTH-1:0] BASE1    = P_ADDR_WIDTH'(P_BUF1_BASE);
  localparam logic [P_ADDR_WIDTH-1:0] FB_STEP  = P_ADDR_WIDTH'(P_FB_WIDTH);

  logic                    frame_sync_q;
  logic                    visible_q;
  logic                    swap_pending;
  logic [REP_W-1:0]        line_rep;
  logic [P_ADDR_WIDTH-1:0] row_base;

  logic                    frame_start;
  logic                    line_end;
  logic                    swap_commit;
  logic                    next_buf;
  logic [P_ADDR_WIDTH-1:0] frame_base;
  logic [P_ADDR_WIDTH-1:0] row_base_cur;
  logic [P_CNT_WIDTH-1:0]  h_scaled;
  logic                    v_coord_unused;
  vga_ctl_t                ctl_in;
  vga_ctl_t                ctl_d;

  assign v_coord_unused = ^ia_v_coord;

  assign frame_start = frame_sync_q & ~i_frame_sync;
  assign line_end    = visible_q & ~i_visible;
  assign swap_commit = frame_start & (swap_pending | i_swap_req);
  assign next_buf    = o_active_buf ^ swap_commit;
  assign frame_base  = next_buf ? BASE1 : BASE0;
  // The first pixel of a frame can share its cycle with frame_start, so bypass the new base
  assign row_base_cur = frame_start ? frame_base : row_base;
  assign h_scaled     = ia_h_coord >> P_SCALE_SHIFT;

  assign ctl_in = '{visible: i_visible, h_sync: i_h_sync, v_sync: i_v_sync};

  vga_delay_line #(
    .P_WIDTH ($bits(vga_ctl_t)),
    .P_DEPTH (1 + P_MEM_LATENCY)
  ) u_ctl_delay (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .data    (ctl_in),
    .delayed (ctl_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_sync_q <= 1'b0;
      visible_q    <= 1'b0;
      swap_pending <= 1'b0;
      line_rep     <= '0;
      row_base     <= BASE0;
      oa_mem_addr  <= '0;
      o_mem_rd_en  <= 1'b0;
      oa_pixel     <= '0;
      o_h_sync     <= 1'b0;
      o_v_sync     <= 1'b0;
      o_swap_ack   <= 1'b0;
      o_active_buf <= 1'b0;
    end else begin
      frame_sync_q <= i_frame_sync;
      visible_q    <= i_visible;
      o_active_buf <= next_buf;
      o_swap_ack   <= swap_commit;

      if (swap_commit)     swap_pending <= 1'b0;
      else if (i_swap_req) swap_pending <= 1'b1;

      if (frame_start) begin
        line_rep <= '0;
        row_base <= frame_base;
      end else if (line_end) begin
        if (line_rep == REP_LAST) begin
          line_rep <= '0;
          row_base <= row_base + FB_STEP;
        end else begin
          line_rep <= line_rep + REP_W'(1);
        end
      end

      oa_mem_addr <= row_base_cur + P_ADDR_WIDTH'(h_scaled);
      o_mem_rd_en <= i_visible;
      oa_pixel    <= ctl_d.visible ? ia_mem_data : '0;
      o_h_sync    <= ctl_d.h_sync;
      o_v_sync    <= ctl_d.v_sync;
    end
  end

endmodule
